// File: rtl/param_cpu_pkg.sv
// Shared definitions for param_cpu: opcode encodings, FSM states and the ALU
// operation select used between the controller and the datapath ALU.
package param_cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDX  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_MOVZ = 4'd7;
    localparam logic [3:0] OP_CLRY = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_JMP  = 4'd11;
    localparam logic [3:0] OP_JZ   = 4'd12;
    localparam logic [3:0] OP_JC   = 4'd13;
    localparam logic [3:0] OP_OUT  = 4'd14;
    localparam logic [3:0] OP_HLT  = 4'd15;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_OUT,
        ST_HALT
    } cpu_state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SHL,
        ALU_SHR,
        ALU_NONE
    } alu_op_t;

    function automatic alu_op_t alu_op_of(input logic [3:0] opcode);
        case (opcode)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            OP_SHL:  return ALU_SHL;
            OP_SHR:  return ALU_SHR;
            default: return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/param_cpu_alu.sv
// Combinational ALU: a is the X operand, b is the Y operand; result replaces Y.
// carry_o is carry-out for ADD, borrow for SUB and the shifted-out bit for shifts.
module param_cpu_alu
    import param_cpu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_t          op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             zero_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum      = '0;
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            ALU_ADD: begin
                sum      = {1'b0, b_i} + {1'b0, a_i};
                result_o = sum[WIDTH-1:0];
                carry_o  = sum[WIDTH];
            end
            ALU_SUB: begin
                // The extra top bit of the difference is set exactly when b < a.
                sum      = {1'b0, b_i} - {1'b0, a_i};
                result_o = sum[WIDTH-1:0];
                carry_o  = sum[WIDTH];
            end
            ALU_AND: result_o = b_i & a_i;
            ALU_OR:  result_o = b_i | a_i;
            ALU_XOR: result_o = b_i ^ a_i;
            ALU_SHL: begin
                result_o = {b_i[WIDTH-2:0], 1'b0};
                carry_o  = b_i[WIDTH-1];
            end
            ALU_SHR: begin
                result_o = {1'b0, b_i[WIDTH-1:1]};
                carry_o  = b_i[0];
            end
            default: begin
                result_o = '0;
                carry_o  = 1'b0;
            end
        endcase
    end

    assign zero_o = ~|result_o;

endmodule

// File: rtl/param_cpu.sv
// Parametrised accumulator CPU: one instruction per clock from a combinational
// program memory, X/Y/Z registers, carry/zero flags, halt and a valid/ready output.
module param_cpu
    import param_cpu_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int PROG_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [$clog2(PROG_DEPTH)-1:0] pc_o,
    input  logic [WIDTH+3:0]              instr_i,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          halted,
    output logic [WIDTH-1:0]              dbg_x,
    output logic [WIDTH-1:0]              dbg_y,
    output logic [WIDTH-1:0]              dbg_z,
    output logic                          dbg_zf,
    output logic                          dbg_cf
);

    localparam int ADDR_W = $clog2(PROG_DEPTH);

    cpu_state_t        state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [WIDTH-1:0]  x_q, y_q, z_q;
    logic              zf_q, cf_q;
    logic [WIDTH-1:0]  out_data_q;
    logic              out_valid_q;
    logic              halted_q;

    logic [3:0]        opcode;
    logic [WIDTH-1:0]  imm;
    logic [ADDR_W-1:0] pc_inc_d;
    logic [ADDR_W-1:0] jmp_target_d;
    alu_op_t           alu_op;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_carry;
    logic              alu_zero;

    assign opcode   = instr_i[WIDTH+3:WIDTH];
    assign imm      = instr_i[WIDTH-1:0];
    assign pc_inc_d = pc_q + ADDR_W'(1);
    assign alu_op   = alu_op_of(opcode);

    // Jump target takes the low address bits of imm, zero-extended for narrow data.
    if (WIDTH >= ADDR_W) begin : g_tgt_trunc
        assign jmp_target_d = imm[ADDR_W-1:0];
    end else begin : g_tgt_ext
        assign jmp_target_d = {{(ADDR_W-WIDTH){1'b0}}, imm};
    end

    param_cpu_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a_i      (x_q),
        .b_i      (y_q),
        .op_i     (alu_op),
        .result_o (alu_result),
        .carry_o  (alu_carry),
        .zero_o   (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pc_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            zf_q        <= 1'b0;
            cf_q        <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    pc_q <= pc_inc_d;
                    case (opcode)
                        OP_LDX: x_q <= imm;
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                            y_q  <= alu_result;
                            cf_q <= alu_carry;
                            zf_q <= alu_zero;
                        end
                        OP_MOVZ: z_q <= y_q;
                        OP_CLRY: y_q <= '0;
                        OP_JMP:  pc_q <= jmp_target_d;
                        OP_JZ:   if (zf_q) pc_q <= jmp_target_d;
                        OP_JC:   if (cf_q) pc_q <= jmp_target_d;
                        OP_OUT: begin
                            out_data_q  <= z_q;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_WAIT_OUT;
                        end
                        OP_HLT: begin
                            pc_q     <= pc_q;
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end
                        default: ;
                    endcase
                end
                ST_WAIT_OUT: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_RUN;
                    end
                end
                ST_HALT: ;
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign pc_o      = pc_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign dbg_x     = x_q;
    assign dbg_y     = y_q;
    assign dbg_z     = z_q;
    assign dbg_zf    = zf_q;
    assign dbg_cf    = cf_q;

    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> out_valid && $stable(out_data));

endmodule

// File: tb/tb_param_cpu.sv
// Bench for param_cpu: a WIDTH=4/DEPTH=16 core and a WIDTH=8/DEPTH=8 core, each
// fed from a bench-owned program array; output transfers go through a scoreboard.
module tb_param_cpu;
    import param_cpu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  pc_a;
    logic [7:0]  instr_a;
    logic [3:0]  out_data_a, x_a, y_a, z_a;
    logic        out_valid_a, out_ready_a, halted_a, zf_a, cf_a;
    logic [7:0]  mem_a [16];
    assign instr_a = mem_a[pc_a];

    logic [2:0]  pc_b;
    logic [11:0] instr_b;
    logic [7:0]  out_data_b, x_b, y_b, z_b;
    logic        out_valid_b, out_ready_b, halted_b, zf_b, cf_b;
    logic [11:0] mem_b [8];
    assign instr_b = mem_b[pc_b];

    param_cpu #(.WIDTH(4), .PROG_DEPTH(16)) u_a (
        .clk(clk), .rst_n(rst_n), .pc_o(pc_a), .instr_i(instr_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .halted(halted_a), .dbg_x(x_a), .dbg_y(y_a), .dbg_z(z_a),
        .dbg_zf(zf_a), .dbg_cf(cf_a)
    );

    param_cpu #(.WIDTH(8), .PROG_DEPTH(8)) u_b (
        .clk(clk), .rst_n(rst_n), .pc_o(pc_b), .instr_i(instr_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .halted(halted_b), .dbg_x(x_b), .dbg_y(y_b), .dbg_z(z_b),
        .dbg_zf(zf_b), .dbg_cf(cf_b)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [3:0] exp_q [$];
    logic [3:0] sb_exp;

    typedef struct {
        logic [11:0] instr;
        logic [2:0]  pc;
        logic [7:0]  x, y, z;
        logic        zf, cf;
    } vec_t;
    vec_t tbl [29];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ia(input logic [3:0] op, input logic [3:0] imm);
        return {op, imm};
    endfunction

    function automatic logic [11:0] ib(input logic [3:0] op, input logic [7:0] imm);
        return {op, imm};
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] imm, input logic [2:0] pc,
                                input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                                input logic zf, input logic cf);
        vec_t v;
        v.instr = {op, imm};
        v.pc = pc; v.x = x; v.y = y; v.z = z; v.zf = zf; v.cf = cf;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) mem_a[i] = ia(OP_NOP, 4'h0);
        for (int i = 0; i < 8; i++)  mem_b[i] = ib(OP_NOP, 8'h00);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_a_zero(input string name);
        check(name, 64'({pc_a, out_data_a, out_valid_a, halted_a, x_a, y_a, z_a, zf_a, cf_a}), 64'd0);
    endtask

    // Scoreboard: a transfer happens on the next edge whenever valid&&ready is seen here.
    always @(negedge clk) begin
        if (rst_n && out_valid_a && out_ready_a) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL out_a unexpected transfer: got 0x%0h required none", out_data_a);
            end else begin
                sb_exp = exp_q.pop_front();
                check("out_a data", 64'(out_data_a), 64'(sb_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, adds, taken, high_cnt;
        out_ready_a = 1'b1;
        out_ready_b = 1'b1;

        // Reset state and pc wrap on the 8-deep core.
        #2;
        hold_reset();
        #1;
        check_a_zero("reset_a");
        check("reset_b", 64'({pc_b, out_data_b, out_valid_b, halted_b, x_b, y_b, z_b, zf_b, cf_b}), 64'd0);
        release_reset();
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("wrap pc step %0d", i), 64'(pc_b), 64'(i % 8));
        end

        // Test plan program 1 on the 4-bit core.
        hold_reset();
        mem_a[0] = ia(OP_LDX, 4'd7);
        mem_a[1] = ia(OP_ADD, 4'd0);
        mem_a[2] = ia(OP_LDX, 4'd9);
        mem_a[3] = ia(OP_ADD, 4'd0);
        mem_a[4] = ia(OP_MOVZ, 4'd0);
        mem_a[5] = ia(OP_OUT, 4'd0);
        mem_a[6] = ia(OP_HLT, 4'd0);
        exp_q.push_back(4'd0);
        out_ready_a = 1'b1;
        release_reset();
        tick(); tick();
        check("p1 y after first add", 64'(y_a), 64'd7);
        tick(); tick();
        check("p1 y/cf/zf after second add", 64'({y_a, cf_a, zf_a}), 64'({4'd0, 1'b1, 1'b1}));
        tick(); tick();
        check("p1 out issue", 64'({out_valid_a, out_data_a, pc_a}), 64'({1'b1, 4'd0, 4'd6}));
        tick();
        check("p1 out done", 64'(out_valid_a), 64'd0);
        tick();
        check("p1 halted", 64'({halted_a, pc_a}), 64'({1'b1, 4'd6}));
        tick();
        check("p1 halt hold", 64'({halted_a, pc_a}), 64'({1'b1, 4'd6}));

        // Table of single-step vectors on the 8-bit core.
        tbl[0]  = mk(OP_LDX,  8'h81, 3'd1, 8'h81, 8'h00, 8'h00, 1'b0, 1'b0);
        tbl[1]  = mk(OP_ADD,  8'h00, 3'd2, 8'h81, 8'h81, 8'h00, 1'b0, 1'b0);
        tbl[2]  = mk(OP_SHL,  8'h00, 3'd3, 8'h81, 8'h02, 8'h00, 1'b0, 1'b1);
        tbl[3]  = mk(OP_CLRY, 8'h00, 3'd4, 8'h81, 8'h00, 8'h00, 1'b0, 1'b1);
        tbl[4]  = mk(OP_ADD,  8'h00, 3'd5, 8'h81, 8'h81, 8'h00, 1'b0, 1'b0);
        tbl[5]  = mk(OP_SHR,  8'h00, 3'd6, 8'h81, 8'h40, 8'h00, 1'b0, 1'b1);
        tbl[6]  = mk(OP_LDX,  8'h40, 3'd7, 8'h40, 8'h40, 8'h00, 1'b0, 1'b1);
        tbl[7]  = mk(OP_SUB,  8'h00, 3'd0, 8'h40, 8'h00, 8'h00, 1'b1, 1'b0);
        tbl[8]  = mk(OP_SUB,  8'h00, 3'd1, 8'h40, 8'hC0, 8'h00, 1'b0, 1'b1);
        tbl[9]  = mk(OP_LDX,  8'h0F, 3'd2, 8'h0F, 8'hC0, 8'h00, 1'b0, 1'b1);
        tbl[10] = mk(OP_AND,  8'h00, 3'd3, 8'h0F, 8'h00, 8'h00, 1'b1, 1'b0);
        tbl[11] = mk(OP_OR,   8'h00, 3'd4, 8'h0F, 8'h0F, 8'h00, 1'b0, 1'b0);
        tbl[12] = mk(OP_XOR,  8'h00, 3'd5, 8'h0F, 8'h00, 8'h00, 1'b1, 1'b0);
        tbl[13] = mk(OP_MOVZ, 8'h00, 3'd6, 8'h0F, 8'h00, 8'h00, 1'b1, 1'b0);
        tbl[14] = mk(OP_LDX,  8'hFF, 3'd7, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
        tbl[15] = mk(OP_ADD,  8'h00, 3'd0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
        tbl[16] = mk(OP_ADD,  8'h00, 3'd1, 8'hFF, 8'hFE, 8'h00, 1'b0, 1'b1);
        tbl[17] = mk(OP_MOVZ, 8'h00, 3'd2, 8'hFF, 8'hFE, 8'hFE, 1'b0, 1'b1);
        tbl[18] = mk(OP_NOP,  8'h00, 3'd3, 8'hFF, 8'hFE, 8'hFE, 1'b0, 1'b1);
        tbl[19] = mk(OP_JZ,   8'h03, 3'd4, 8'hFF, 8'hFE, 8'hFE, 1'b0, 1'b1);
        tbl[20] = mk(OP_JC,   8'h05, 3'd5, 8'hFF, 8'hFE, 8'hFE, 1'b0, 1'b1);
        tbl[21] = mk(OP_JMP,  8'h1F, 3'd7, 8'hFF, 8'hFE, 8'hFE, 1'b0, 1'b1);
        tbl[22] = mk(OP_NOP,  8'h00, 3'd0, 8'hFF, 8'hFE, 8'hFE, 1'b0, 1'b1);
        tbl[23] = mk(OP_SHL,  8'h00, 3'd1, 8'hFF, 8'hFC, 8'hFE, 1'b0, 1'b1);
        tbl[24] = mk(OP_LDX,  8'hFC, 3'd2, 8'hFC, 8'hFC, 8'hFE, 1'b0, 1'b1);
        tbl[25] = mk(OP_SUB,  8'h00, 3'd3, 8'hFC, 8'h00, 8'hFE, 1'b1, 1'b0);
        tbl[26] = mk(OP_JZ,   8'h06, 3'd6, 8'hFC, 8'h00, 8'hFE, 1'b1, 1'b0);
        tbl[27] = mk(OP_JC,   8'h00, 3'd7, 8'hFC, 8'h00, 8'hFE, 1'b1, 1'b0);
        tbl[28] = mk(OP_CLRY, 8'h00, 3'd0, 8'hFC, 8'h00, 8'hFE, 1'b1, 1'b0);
        hold_reset();
        release_reset();
        for (int i = 0; i < 29; i++) begin
            mem_b[pc_b] = tbl[i].instr;
            tick();
            check($sformatf("vec%0d op%0d", i, tbl[i].instr[11:8]),
                  64'({pc_b, x_b, y_b, z_b, zf_b, cf_b}),
                  64'({tbl[i].pc, tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].zf, tbl[i].cf}));
        end

        // 8-bit counting loop: exits through JC on the 256th ADD.
        hold_reset();
        mem_b[0] = ib(OP_LDX, 8'd1);
        mem_b[1] = ib(OP_ADD, 8'd0);
        mem_b[2] = ib(OP_JC,  8'd4);
        mem_b[3] = ib(OP_JMP, 8'd1);
        mem_b[4] = ib(OP_HLT, 8'd0);
        release_reset();
        cyc = 0; adds = 0; taken = 0;
        while (!halted_b && cyc < 1200) begin
            if (pc_b == 3'd1) adds++;
            if (pc_b == 3'd2 && cf_b) taken++;
            tick();
            cyc++;
        end
        check("loop halted within budget", 64'(halted_b), 64'd1);
        check("loop add count", 64'(adds), 64'd256);
        check("loop jc taken count", 64'(taken), 64'd1);
        check("loop final y/cf/zf/pc", 64'({y_b, cf_b, zf_b, pc_b}), 64'({8'd0, 1'b1, 1'b1, 3'd4}));

        // OUT back-pressured for five WAIT_OUT edges.
        hold_reset();
        mem_a[0] = ia(OP_LDX, 4'd5);
        mem_a[1] = ia(OP_ADD, 4'd0);
        mem_a[2] = ia(OP_MOVZ, 4'd0);
        mem_a[3] = ia(OP_OUT, 4'd0);
        mem_a[4] = ia(OP_LDX, 4'd3);
        mem_a[5] = ia(OP_HLT, 4'd0);
        out_ready_a = 1'b0;
        exp_q.push_back(4'd5);
        release_reset();
        tick(); tick(); tick(); tick();
        high_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            if (out_valid_a) high_cnt++;
            check($sformatf("wait hold %0d", k), 64'({out_valid_a, out_data_a, pc_a}),
                  64'({1'b1, 4'd5, 4'd4}));
        end
        out_ready_a = 1'b1;
        tick();
        check("wait transfer", 64'({out_valid_a, pc_a, x_a}), 64'({1'b0, 4'd4, 4'd5}));
        check("wait valid cycles", 64'(high_cnt), 64'd6);
        tick();
        check("wait next instr", 64'({x_a, pc_a}), 64'({4'd3, 4'd5}));

        // Reset in the middle of WAIT_OUT.
        hold_reset();
        mem_a[0] = ia(OP_LDX, 4'd6);
        mem_a[1] = ia(OP_ADD, 4'd0);
        mem_a[2] = ia(OP_MOVZ, 4'd0);
        mem_a[3] = ia(OP_OUT, 4'd0);
        out_ready_a = 1'b0;
        release_reset();
        tick(); tick(); tick(); tick();
        check("rst-wait pre", 64'({out_valid_a, out_data_a}), 64'({1'b1, 4'd6}));
        #3;
        hold_reset();
        mem_a[0] = ia(OP_LDX, 4'd2);
        #1;
        check_a_zero("rst-wait async");
        out_ready_a = 1'b1;
        release_reset();
        tick();
        check("rst-wait restart", 64'({pc_a, x_a, out_valid_a}), 64'({4'd1, 4'd2, 1'b0}));

        // Reset while halted.
        hold_reset();
        mem_a[0] = ia(OP_LDX, 4'd3);
        mem_a[1] = ia(OP_ADD, 4'd0);
        mem_a[2] = ia(OP_HLT, 4'd0);
        release_reset();
        tick(); tick(); tick();
        check("rst-halt pre", 64'({halted_a, pc_a, y_a}), 64'({1'b1, 4'd2, 4'd3}));
        #3;
        rst_n = 1'b0;
        #1;
        check_a_zero("rst-halt async");
        release_reset();
        tick();
        check("rst-halt restart", 64'({halted_a, pc_a, x_a}), 64'({1'b0, 4'd1, 4'd3}));

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/param_cpu.md
# param_cpu

Parametrised successor of the 4-bit accumulator CPU. Fetches `{opcode, immediate}` words from an external combinational program memory, executes one instruction per clock through X/Y/Z registers and an ALU, and supports conditional jumps, carry/zero flags, halt, and a valid/ready output port. It sits at the top of the datapath, in place of the fixed counter/controller/register set.

## Interface
Parameters:
- `WIDTH`, 4: data width of X, Y, Z, the ALU and the immediate field; must be ≥2.
- `PROG_DEPTH`, 16: number of program words; power of two, ≥2. `ADDR_W = $clog2(PROG_DEPTH)`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_o`  out  ADDR_W  program-memory address.
- `instr_i`  in  4+WIDTH  instruction at `pc_o`, same cycle: `[WIDTH+3:WIDTH]` is the opcode, `[WIDTH-1:0]` is the immediate.
- `out_data`  out  WIDTH  output word.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts.
- `halted`  out  1  core is in HALT.
- `dbg_x`, `dbg_y`, `dbg_z`  out  WIDTH each  register contents.
- `dbg_zf`, `dbg_cf`  out  1 each  zero and carry flags.

## Operation
- States: RUN, WAIT_OUT, HALT.
- RUN executes `instr_i` on every edge. WAIT_OUT and HALT execute nothing and hold `pc_o`.
- Opcodes. The ALU takes a=X, b=Y; result is WIDTH bits. Every opcode not listed as a jump sets pc ← pc+1.
  - 0 NOP: no effect.
  - 1 LDX: X ← imm.
  - 2 ADD: Y ← Y+X; cf = carry out.
  - 3 SUB: Y ← Y−X; cf = borrow (Y<X unsigned).
  - 4 AND, 5 OR, 6 XOR: Y ← Y op X; cf ← 0.
  - 7 MOVZ: Z ← Y.
  - 8 CLRY: Y ← 0; flags unchanged.
  - 9 SHL: Y ← Y<<1; cf = old Y[WIDTH-1].
  - 10 SHR: Y ← Y>>1 (logical); cf = old Y[0].
  - 11 JMP: pc ← imm[ADDR_W-1:0].
  - 12 JZ: pc ← target if zf, else pc+1.
  - 13 JC: pc ← target if cf, else pc+1.
  - 14 OUT: out_data ← Z; out_valid ← 1; go to WAIT_OUT.
  - 15 HLT: go to HALT; pc holds at the HLT address.
- zf ← (result == 0) for opcodes 2–6 and 9–10 only. Every other opcode leaves both flags unchanged.
- The jump target uses the low ADDR_W bits of imm. Bits above ADDR_W are ignored. If `WIDTH < ADDR_W`, the target is zero-extended.
- pc increment wraps from PROG_DEPTH−1 to 0.
- WAIT_OUT: on an edge where `out_valid && out_ready`, out_valid ← 0 and the state returns to RUN. `out_data` is stable while out_valid is high.
- HALT is left only by reset.

## Timing
- Reset value of every output and register is 0, with state RUN. After reset the instruction at address 0 executes on the first edge.
- Instruction fetch is combinational: one instruction per cycle in RUN. Jumps cost no extra cycles.
- OUT costs at least 2 cycles: the issue edge, then at least one WAIT_OUT edge. `out_ready` sampled high on the first WAIT_OUT edge completes the transfer.
- Results appear on `dbg_*` and `dbg_*f` on the edge that executes the instruction.
- `halted` rises on the HLT edge.
- Reset asserted mid-WAIT_OUT drops `out_valid` immediately (asynchronously), and no transfer is counted.
- Flags written by an ALU op are visible to a JZ/JC in the very next instruction.

## Structure
- Package `param_cpu_pkg`: opcode localparams (`OP_NOP`…`OP_HLT`), the state enum `cpu_state_t`, and the ALU-op encoding.
- Sub-module `param_cpu_alu`: combinational. Inputs a, b and op. Outputs result, carry and zero, with WIDTH parameter.
- Top contains the FSM, pc, X/Y/Z, flags and the output register.

## Test plan
- WIDTH=4. Program: LDX 7; ADD; LDX 9; ADD; MOVZ; OUT; HLT. Hold `out_ready`=1. Required: Y=0 after the second ADD, cf=1, zf=1, out_data=0. Then `halted`=1 with pc=6.
- WIDTH=8. Loop: LDX 1; ADD; JC exit; JMP 1. Required: carry on Y 255→0 after 256 ADDs. JC is taken exactly once.
- OUT with `out_ready`=0 for 5 cycles, then 1. Required: out_valid high for 6 cycles, data constant, pc frozen. The next instruction executes one cycle after the transfer.
- PROG_DEPTH=8, program of NOPs. Required: pc sequence 0..7,0 with wrap. JMP imm=0x1F lands on pc=7.
- SHL/SHR on Y=8'h81. Required: SHL gives 8'h02 with cf=1; SHR of 8'h81 gives 8'h40 with cf=1; CLRY leaves flags unchanged.
- Assert `rst_n` low during WAIT_OUT and during HALT. Required: all outputs 0 asynchronously, and execution restarts at address 0.
